// File: rtl/fcpu_pkg.sv
// fcpu_pkg: shared types and constants for the fcpu io bridge
package fcpu_pkg;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} io_wstate_t;
  typedef enum logic {R_IDLE, R_DATA} io_rstate_t;
  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
endpackage

// File: rtl/fcpu_byte_fifo.sv
// fcpu_byte_fifo: synchronous first-word-fall-through byte FIFO
module fcpu_byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     push,
  input  logic [7:0]               din,
  input  logic                     pop,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0]  mem_q [DEPTH];
  logic [7:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;
  always_comb begin
    full    = cnt_q == (AW+1)'(DEPTH);
    empty   = cnt_q == '0;
    count   = cnt_q;
    dout    = empty ? 8'h00 : mem_q[rd_q];
    do_push = push && !full;
    do_pop  = pop && !empty;
    mem_d   = mem_q;
    if (do_push) mem_d[wr_q] = din;
    wr_d    = do_push ? wr_q + 1'b1 : wr_q;
    rd_d    = do_pop ? rd_q + 1'b1 : rd_q;
    cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  always_ff @(posedge clk) begin
    if (!nrst) begin
      mem_q <= '{default: '0};
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/fcpu_io_bridge.sv
// fcpu_io_bridge: AXI4 slave turning fcpu io_* bursts into serial TX/RX byte streams
module fcpu_io_bridge
  import fcpu_pkg::*;
#(
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [3:0]  io_awid,
  input  logic [31:0] io_awaddr,
  input  logic [7:0]  io_awlen,
  input  logic        io_awvalid,
  output logic        io_awready,
  input  logic [7:0]  io_wdata,
  input  logic        io_wstrb,
  input  logic        io_wlast,
  input  logic        io_wvalid,
  output logic        io_wready,
  output logic [3:0]  io_bid,
  output logic [1:0]  io_bresp,
  output logic        io_bvalid,
  input  logic        io_bready,
  input  logic [3:0]  io_arid,
  input  logic [31:0] io_araddr,
  input  logic [7:0]  io_arlen,
  input  logic        io_arvalid,
  output logic        io_arready,
  output logic [3:0]  io_rid,
  output logic [7:0]  io_rdata,
  output logic [1:0]  io_rresp,
  output logic        io_rlast,
  output logic        io_rvalid,
  input  logic        io_rready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);
  io_wstate_t w_q, w_d;
  io_rstate_t r_q, r_d;
  logic [3:0] bid_q, bid_d, rid_q, rid_d;
  logic [7:0] cnt_q, cnt_d;
  logic tx_full, tx_empty, rx_full, rx_empty;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic [$clog2(TX_DEPTH):0] tx_count;
  logic [$clog2(RX_DEPTH):0] rx_count;
  logic unused_sink;
  assign unused_sink = ^{io_awaddr, io_awlen, io_araddr, tx_count, rx_count};
  fcpu_byte_fifo #(.DEPTH(TX_DEPTH)) u_tx (
    .clk(clk), .nrst(nrst), .push(w_hs && io_wstrb), .din(io_wdata),
    .pop(tx_ready), .dout(tx_data), .full(tx_full), .empty(tx_empty), .count(tx_count)
  );
  fcpu_byte_fifo #(.DEPTH(RX_DEPTH)) u_rx (
    .clk(clk), .nrst(nrst), .push(rx_valid), .din(rx_data),
    .pop(r_hs), .dout(io_rdata), .full(rx_full), .empty(rx_empty), .count(rx_count)
  );
  always_comb begin
    tx_valid   = !tx_empty;
    rx_ready   = !rx_full;
    io_awready = w_q == W_IDLE;
    io_wready  = w_q == W_DATA && !tx_full;
    io_bvalid  = w_q == W_RESP;
    io_bid     = bid_q;
    io_bresp   = AXI_RESP_OKAY;
    io_arready = r_q == R_IDLE;
    io_rvalid  = r_q == R_DATA && !rx_empty;
    io_rlast   = r_q == R_DATA && cnt_q == 8'd0;
    io_rid     = rid_q;
    io_rresp   = AXI_RESP_OKAY;
    aw_hs      = io_awvalid && io_awready;
    w_hs       = io_wvalid && io_wready;
    b_hs       = io_bvalid && io_bready;
    ar_hs      = io_arvalid && io_arready;
    r_hs       = io_rvalid && io_rready;
    w_d        = aw_hs ? W_DATA : (w_hs && io_wlast) ? W_RESP : b_hs ? W_IDLE : w_q;
    bid_d      = aw_hs ? io_awid : bid_q;
    r_d        = ar_hs ? R_DATA : (r_hs && io_rlast) ? R_IDLE : r_q;
    rid_d      = ar_hs ? io_arid : rid_q;
    cnt_d      = ar_hs ? io_arlen : r_hs ? cnt_q - 8'd1 : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (!nrst) begin
      w_q   <= W_IDLE;
      r_q   <= R_IDLE;
      bid_q <= '0;
      rid_q <= '0;
      cnt_q <= '0;
    end else begin
      w_q   <= w_d;
      r_q   <= r_d;
      bid_q <= bid_d;
      rid_q <= rid_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_fcpu_io_bridge.sv
// tb_fcpu_io_bridge: scoreboard bench driving directed AXI bursts and serial bytes
module tb_fcpu_io_bridge;
  logic clk = 0;
  logic nrst = 0;
  logic [3:0] io_awid = 0, io_arid = 0, io_bid, io_rid;
  logic [31:0] io_awaddr = 0, io_araddr = 0;
  logic [7:0] io_awlen = 0, io_arlen = 0, io_wdata = 0, io_rdata, tx_data, rx_data = 0;
  logic io_awvalid = 0, io_awready, io_wstrb = 0, io_wlast = 0, io_wvalid = 0, io_wready;
  logic [1:0] io_bresp, io_rresp;
  logic io_bvalid, io_bready = 1, io_arvalid = 0, io_arready;
  logic io_rlast, io_rvalid, io_rready = 1;
  logic tx_valid, tx_ready = 1, rx_valid = 0, rx_ready;
  typedef struct { logic [3:0] id; logic [7:0] d; logic l; } r_t;
  logic [7:0] tx_exp[$];
  logic [3:0] b_exp[$];
  r_t r_exp[$];
  logic [3:0] cur_id;
  int vecs = 0, miss = 0;
  always #5 clk = ~clk;
  fcpu_io_bridge #(.TX_DEPTH(4), .RX_DEPTH(4)) dut (
    .clk(clk), .nrst(nrst),
    .io_awid(io_awid), .io_awaddr(io_awaddr), .io_awlen(io_awlen), .io_awvalid(io_awvalid), .io_awready(io_awready),
    .io_wdata(io_wdata), .io_wstrb(io_wstrb), .io_wlast(io_wlast), .io_wvalid(io_wvalid), .io_wready(io_wready),
    .io_bid(io_bid), .io_bresp(io_bresp), .io_bvalid(io_bvalid), .io_bready(io_bready),
    .io_arid(io_arid), .io_araddr(io_araddr), .io_arlen(io_arlen), .io_arvalid(io_arvalid), .io_arready(io_arready),
    .io_rid(io_rid), .io_rdata(io_rdata), .io_rresp(io_rresp), .io_rlast(io_rlast), .io_rvalid(io_rvalid), .io_rready(io_rready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
  );
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    vecs++;
    if (a !== e) begin
      miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic aw(input logic [3:0] id);
    int t = 0;
    io_awid = id;
    io_awvalid = 1;
    cur_id = id;
    @(negedge clk);
    while (!io_awready && t < 100) begin t++; @(negedge clk); end
    if (t >= 100) chk("aw_timeout", 1, 0);
    tick;
    io_awvalid = 0;
  endtask
  task automatic w_beat(input logic [7:0] d, input logic s, input logic l);
    int t = 0;
    io_wdata = d;
    io_wstrb = s;
    io_wlast = l;
    io_wvalid = 1;
    if (s) tx_exp.push_back(d);
    if (l) b_exp.push_back(cur_id);
    @(negedge clk);
    while (!io_wready && t < 200) begin t++; @(negedge clk); end
    if (t >= 200) chk("w_timeout", 1, 0);
    tick;
    io_wvalid = 0;
    io_wlast = 0;
  endtask
  task automatic ar(input logic [3:0] id, input logic [7:0] len);
    int t = 0;
    io_arid = id;
    io_arlen = len;
    io_arvalid = 1;
    @(negedge clk);
    while (!io_arready && t < 100) begin t++; @(negedge clk); end
    if (t >= 100) chk("ar_timeout", 1, 0);
    tick;
    io_arvalid = 0;
  endtask
  task automatic rx_send(input logic [7:0] d);
    int t = 0;
    rx_data = d;
    rx_valid = 1;
    @(negedge clk);
    while (!rx_ready && t < 200) begin t++; @(negedge clk); end
    if (t >= 200) chk("rx_timeout", 1, 0);
    tick;
    rx_valid = 0;
  endtask
  task automatic push_r(input logic [3:0] id, input logic [7:0] d, input logic l);
    r_t e;
    e.id = id;
    e.d = d;
    e.l = l;
    r_exp.push_back(e);
  endtask
  task automatic drain;
    int t = 0;
    while ((tx_exp.size() + b_exp.size() + r_exp.size()) != 0 && t < 500) begin t++; tick; end
    chk("drain_left", tx_exp.size() + b_exp.size() + r_exp.size(), 0);
  endtask
  task automatic check_reset;
    chk("rst_awready", io_awready, 1);
    chk("rst_arready", io_arready, 1);
    chk("rst_wready", io_wready, 0);
    chk("rst_bvalid", io_bvalid, 0);
    chk("rst_rvalid", io_rvalid, 0);
    chk("rst_rlast", io_rlast, 0);
    chk("rst_bid", io_bid, 0);
    chk("rst_rid", io_rid, 0);
    chk("rst_bresp", io_bresp, 0);
    chk("rst_rresp", io_rresp, 0);
    chk("rst_rdata", io_rdata, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_rx_ready", rx_ready, 1);
  endtask
  always @(negedge clk) if (nrst) begin
    if (tx_valid && tx_ready) begin
      if (tx_exp.size() == 0) chk("tx_unexpected", tx_data, 32'hffff_ffff);
      else chk("tx_data", tx_data, tx_exp.pop_front());
    end
    if (io_bvalid && io_bready) begin
      if (b_exp.size() == 0) chk("b_unexpected", io_bid, 32'hffff_ffff);
      else begin
        chk("bid", io_bid, b_exp.pop_front());
        chk("bresp", io_bresp, 0);
      end
    end
    if (io_rvalid && io_rready) begin
      if (r_exp.size() == 0) chk("r_unexpected", io_rdata, 32'hffff_ffff);
      else begin
        r_t e;
        e = r_exp.pop_front();
        chk("rid", io_rid, e.id);
        chk("rdata", io_rdata, e.d);
        chk("rlast", io_rlast, e.l);
        chk("rresp", io_rresp, 0);
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    repeat (2) tick;
    nrst = 1;
    check_reset;
    aw(3);
    w_beat(8'h41, 1, 1);
    chk("tx_valid_lat", tx_valid, 1);
    chk("bvalid_lat", io_bvalid, 1);
    drain;
    tx_ready = 0;
    aw(1);
    for (int i = 0; i < 4; i++) w_beat(8'h10 + 8'(i), 1, 0);
    io_wdata = 8'h14;
    io_wstrb = 1;
    io_wvalid = 1;
    repeat (3) begin
      @(negedge clk);
      chk("wready_full", io_wready, 0);
      chk("bvalid_early", io_bvalid, 0);
    end
    tick;
    io_wvalid = 0;
    tx_ready = 1;
    w_beat(8'h14, 1, 0);
    w_beat(8'h15, 1, 1);
    drain;
    aw(2);
    w_beat(8'h21, 1, 0);
    w_beat(8'h22, 0, 0);
    w_beat(8'h23, 1, 1);
    drain;
    ar(5, 0);
    repeat (20) begin
      @(negedge clk);
      chk("rvalid_empty", io_rvalid, 0);
    end
    tick;
    push_r(5, 8'h5a, 1);
    rx_send(8'h5a);
    chk("rvalid_lat", io_rvalid, 1);
    drain;
    for (int i = 0; i < 4; i++) rx_send(8'h50 + 8'(i));
    rx_data = 8'h54;
    rx_valid = 1;
    @(negedge clk);
    chk("rx_ready_full", rx_ready, 0);
    tick;
    for (int i = 0; i < 5; i++) push_r(6, 8'h50 + 8'(i), i == 4);
    fork
      rx_send(8'h54);
      ar(6, 4);
    join
    drain;
    tx_ready = 0;
    aw(7);
    w_beat(8'h61, 1, 0);
    w_beat(8'h62, 1, 0);
    rx_send(8'h71);
    rx_send(8'h72);
    io_wdata = 8'h63;
    io_wstrb = 1;
    io_wvalid = 1;
    nrst = 0;
    tick;
    nrst = 1;
    io_wvalid = 0;
    tx_exp.delete();
    b_exp.delete();
    r_exp.delete();
    check_reset;
    tx_ready = 1;
    aw(8);
    w_beat(8'h88, 1, 1);
    drain;
    ar(9, 0);
    repeat (5) begin
      @(negedge clk);
      chk("rvalid_after_rst", io_rvalid, 0);
    end
    tick;
    push_r(9, 8'h99, 1);
    rx_send(8'h99);
    drain;
    repeat (5) tick;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
